// File: rtl/branch_redirect_unit.sv
// Branch resolution and registered fetch redirect with a one-cycle IF/ID flush.
// Optional taken/branch statistics counters are compiled in with `define BRANCH_STATS_EN.
module branch_redirect_unit #(
    parameter int ADDR_W    = 32,
    parameter int IMM_SHIFT = 2
`ifdef BRANCH_STATS_EN
    ,
    parameter int STAT_W    = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [2:0]        id_br_type,
    input  logic [1:0]        cmp_code,
    input  logic [ADDR_W-1:0] id_pc,
    input  logic [ADDR_W-1:0] id_imm,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              redirect_ready,
    output logic              flush_ifid,
    output logic              stall_id,
`ifdef BRANCH_STATS_EN
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_taken,
`endif
    output logic              dbg_state_o
);

    // Handshake: a redirect transfers on a rising edge where redirect_valid and
    // redirect_ready are both 1; redirect_valid/redirect_pc stay stable until then.
    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    localparam logic [2:0] BR_NONE = 3'd0, BR_BEQ = 3'd1, BR_BNE = 3'd2, BR_BLT = 3'd3;
    localparam logic [2:0] BR_BGT  = 3'd4, BR_BLE = 3'd5, BR_BGE = 3'd6, BR_JMP = 3'd7;

    state_t              state_q, state_d;
    logic                redirect_valid_q, redirect_valid_d;
    logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic                flush_q, flush_d;
    logic                is_eq, is_lt, is_gt, br_taken, accept;
    logic [ADDR_W-1:0]   target;

    always_comb begin
        is_eq    = (cmp_code == 2'b01);
        is_lt    = (cmp_code == 2'b10);
        is_gt    = (cmp_code == 2'b11);
        br_taken = 1'b0;
        case (id_br_type)
            BR_BEQ:  br_taken = is_eq;
            BR_BNE:  br_taken = is_lt | is_gt;   // DEFAULT code never takes a conditional
            BR_BLT:  br_taken = is_lt;
            BR_BGT:  br_taken = is_gt;
            BR_BLE:  br_taken = is_lt | is_eq;
            BR_BGE:  br_taken = is_gt | is_eq;
            BR_JMP:  br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    assign accept = id_valid && (id_br_type != BR_NONE) && (state_q == S_IDLE);
    assign target = (id_br_type == BR_JMP) ? id_imm
                                           : id_pc + ADDR_W'(4) + (id_imm << IMM_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && br_taken) state_d = S_WAIT;
            S_WAIT:  if (redirect_valid_q && redirect_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = 1'b0;
        if (accept && br_taken) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target;
            flush_d          = 1'b1;
        end else if (state_q == S_WAIT && redirect_valid_q && redirect_ready) begin
            redirect_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_ifid     = flush_q;
    assign stall_id       = (state_q == S_WAIT);
    assign dbg_state_o    = state_q;

`ifdef BRANCH_STATS_EN
    logic              is_cond;
    logic [STAT_W-1:0] stat_branches_q, stat_taken_q;

    assign is_cond = (id_br_type != BR_NONE) && (id_br_type != BR_JMP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q <= '0;
            stat_taken_q    <= '0;
        end else if (accept) begin
            if (is_cond)  stat_branches_q <= stat_branches_q + 1'b1;
            if (br_taken) stat_taken_q    <= stat_taken_q + 1'b1;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_taken    = stat_taken_q;
`endif

endmodule
